// File: rtl/parity_chk_pkg.sv
// ============================================================================
//  Module      : parity_chk_pkg
//  Description : Shared definitions for the column-parity frame checker:
//                FSM state encoding, error-counter width and the helper that
//                sizes the in-frame word counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package parity_chk_pkg;

  // Frame checker FSM states
  typedef enum logic [1:0] {
    ST_ACC    = 2'd0,  // accepting data words
    ST_CHK    = 2'd1,  // accepting the parity word
    ST_REPORT = 2'd2   // result held for the consumer
  } state_t;

  // Width of the optional error-frame counter
  localparam int ERR_CNT_W = 16;

  // Counter must be able to hold the value FRAME_LEN itself
  function automatic int cnt_width(input int frame_len);
    return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
  endfunction

endpackage : parity_chk_pkg

`default_nettype wire

// File: rtl/parity_frame_chk_if.sv
// ============================================================================
//  Module      : parity_frame_chk_if
//  Description : Word-input and result handshakes of the parity frame checker.
//  Signals     : in_valid / in_data / in_ready         word stream
//                res_valid / res_ready                 result handshake
//                res_syndrome / res_err                result payload
//  Modports    : master - producer of words / consumer of results
//                slave  - the checker
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface parity_frame_chk_if #(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_syndrome;
  logic              res_err;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  res_valid,
    output res_ready,
    input  res_syndrome,
    input  res_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output res_valid,
    input  res_ready,
    output res_syndrome,
    output res_err
  );

endinterface : parity_frame_chk_if

`default_nettype wire

// File: rtl/parity_frame_chk_xor_word.sv
// ============================================================================
//  Module      : xor_word
//  Description : Word-wide XOR built from one gate-primitive xor per bit.
//  Ports       : a  in  DATA_W   operand A
//                b  in  DATA_W   operand B
//                y  out DATA_W   a ^ b
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module xor_word #(
  parameter int DATA_W = 8
) (
  input  wire logic [DATA_W-1:0] a,
  input  wire logic [DATA_W-1:0] b,
  output wire logic [DATA_W-1:0] y
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    xor u_xor (y[i], a[i], b[i]);
  end

endmodule : xor_word

`default_nettype wire

// File: rtl/parity_frame_chk.sv
// ============================================================================
//  Module      : parity_frame_chk
//  Description : Column-parity frame checker. XOR-accumulates FRAME_LEN data
//                words, compares against the trailing parity word and
//                presents the syndrome plus an error flag on a result
//                handshake.
//  Ports       : clk      in   clock, rising edge
//                rst      in   asynchronous active-high reset
//                bus      slave modport of parity_frame_chk_if
//                err_cnt  out  16-bit saturating error-frame count
//                              (only with PARITY_CHK_ERR_CNT_EN defined)
//  Options     : PARITY_CHK_ERR_CNT_EN - adds the error-frame counter
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module parity_frame_chk
  import parity_chk_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  parity_frame_chk_if.slave      bus
`ifdef PARITY_CHK_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);

  localparam int                 CNT_W      = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("parity_frame_chk: DATA_W must be at least 1");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame_len
    $error("parity_frame_chk: FRAME_LEN must be at least 1");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_syn;

  logic                w_in_ready;
  logic                w_res_valid;
  logic                w_in_acc;
  logic                w_res_hs;
  logic                w_res_err;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic [DATA_W-1:0]   w_syn_nxt;

  assign w_in_acc  = bus.in_valid && w_in_ready;
  assign w_res_hs  = w_res_valid && bus.res_ready;
  assign w_res_err = |r_syn;

  // Accumulator update and syndrome both come from gate-level XOR words
  xor_word #(.DATA_W(DATA_W)) u_acc_xor (
    .a (r_acc),
    .b (bus.in_data),
    .y (w_acc_nxt)
  );

  xor_word #(.DATA_W(DATA_W)) u_syn_xor (
    .a (r_acc),
    .b (bus.in_data),
    .y (w_syn_nxt)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC: begin
        // The accept that brings the count to FRAME_LEN ends the data phase
        if (w_in_acc && (r_cnt == C_CNT_LAST)) begin
          w_state_nxt = ST_CHK;
        end
      end
      ST_CHK: begin
        if (w_in_acc) begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (w_res_hs) begin
          w_state_nxt = ST_ACC;
        end
      end
      default: begin
        w_state_nxt = ST_ACC;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      ST_ACC, ST_CHK: w_in_ready  = 1'b1;
      ST_REPORT:      w_res_valid = 1'b1;
      default:        w_in_ready  = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: accumulator, word counter, syndrome
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_syn <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_in_acc) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        ST_CHK: begin
          // Syndrome is only written here, so it stays frozen throughout REPORT
          if (w_in_acc) begin
            r_syn <= w_syn_nxt;
          end
        end
        ST_REPORT: begin
          if (w_res_hs) begin
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        default: begin
          r_acc <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.res_valid    = w_res_valid;
  assign bus.res_syndrome = r_syn;
  assign bus.res_err      = w_res_err;

`ifdef PARITY_CHK_ERR_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating error-frame counter, cleared only by reset
  // --------------------------------------------------------------------------
  localparam logic [ERR_CNT_W-1:0] C_ERR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] C_ERR_ONE = ERR_CNT_W'(1);

  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_res_hs && w_res_err && (r_err_cnt != C_ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + C_ERR_ONE;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule : parity_frame_chk

`default_nettype wire

// File: tb/tb_parity_frame_chk.sv
// ============================================================================
//  Module      : tb_parity_frame_chk
//  Description : Self-checking bench for parity_frame_chk (DATA_W=8,
//                FRAME_LEN=4). Expected syndromes are queued when a frame is
//                driven and popped when the result handshake completes.
//  Options     : PARITY_CHK_ERR_CNT_EN - also exercises err_cnt
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parity_frame_chk;
  import parity_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parity_frame_chk_if #(.DATA_W(8)) bus ();

`ifdef PARITY_CHK_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
`endif

  parity_frame_chk #(.DATA_W(8), .FRAME_LEN(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus)
`ifdef PARITY_CHK_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         cycle    = 0;
  logic [7:0] sb_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it is accepted (bounded)
  task automatic send_word(input logic [7:0] w, input string tag);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check({tag, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d0, d1, d2, d3, p, input string tag);
    sb_q.push_back(d0 ^ d1 ^ d2 ^ d3 ^ p);
    send_word(d0, tag);
    send_word(d1, tag);
    send_word(d2, tag);
    send_word(d3, tag);
    send_word(p,  tag);
    // Result must be visible on the cycle right after the parity accept
    check({tag, "_latency"}, 32'(bus.res_valid), 32'd1);
  endtask

  // Wait for a result, compare against the scoreboard, then complete the handshake
  task automatic take_result(input string tag);
    int         guard = 0;
    logic [7:0] exp;
    while (bus.res_valid !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_syndrome"}, 32'(bus.res_syndrome), 32'(exp));
      check({tag, "_err"},      32'(bus.res_err),      32'(|exp));
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    logic [7:0] words[10];
    logic [7:0] exp;
    int         rise[2];
    int         nres;
    int         idx;
    int         guard;
    logic       rdy_before;

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_in_ready",  32'(bus.in_ready),     32'd1);
    check("rst_res_valid", 32'(bus.res_valid),    32'd0);
    check("rst_syndrome",  32'(bus.res_syndrome), 32'h00);
    check("rst_res_err",   32'(bus.res_err),      32'd0);
`ifdef PARITY_CHK_ERR_CNT_EN
    check("rst_err_cnt",   32'(err_cnt),          32'd0);
`endif

    // Clean frame and single-bit error
    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, "clean");
    take_result("clean");
    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0E, "bit_err");
    take_result("bit_err");

    // Reset mid-frame: syndrome currently 0x01, must clear asynchronously
    send_word(8'hAA, "midrst");
    send_word(8'h55, "midrst");
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready",  32'(bus.in_ready),     32'd1);
    check("midrst_res_valid", 32'(bus.res_valid),    32'd0);
    check("midrst_syndrome",  32'(bus.res_syndrome), 32'h00);
    check("midrst_res_err",   32'(bus.res_err),      32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_result", 32'(bus.res_valid), 32'd0);
    send_frame(8'h10, 8'h20, 8'h40, 8'h80, 8'hF0, "after_rst");
    take_result("after_rst");

    // Backpressure: result held for 3 cycles while a word is offered
    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0C, "bp");
    exp = sb_q.pop_front();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid",    32'(bus.res_valid),    32'd1);
      check("bp_hold_syndrome", 32'(bus.res_syndrome), 32'(exp));
      check("bp_hold_err",      32'(bus.res_err),      32'(|exp));
      check("bp_hold_in_ready", 32'(bus.in_ready),     32'd0);
    end
    // Handshake cycle with in_valid still high: the word must not be taken
    bus.res_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    check("bp_valid_drop", 32'(bus.res_valid), 32'd0);
    check("bp_ready_back", 32'(bus.in_ready),  32'd1);
    // A consumed 0xFF would corrupt this clean frame
    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, "bp_next");
    take_result("bp_next");

    // Back-to-back frames with in_valid and res_ready held high
    words = '{8'h11, 8'h22, 8'h44, 8'h88, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    sb_q.push_back(8'h00);
    sb_q.push_back(8'h01);
    bus.res_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = words[0];
    idx   = 0;
    nres  = 0;
    guard = 0;
    rise  = '{0, 0};
    while ((idx < 10 || nres < 2) && guard < 40) begin
      rdy_before = bus.in_ready;
      tick();
      guard++;
      if (rdy_before && idx < 10) begin
        idx++;
        if (idx < 10) bus.in_data = words[idx];
        else          bus.in_valid = 1'b0;
      end
      if (bus.res_valid === 1'b1 && nres < 2) begin
        rise[nres] = cycle;
        exp = sb_q.pop_front();
        check("b2b_syndrome", 32'(bus.res_syndrome), 32'(exp));
        check("b2b_err",      32'(bus.res_err),      32'(|exp));
        nres++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    check("b2b_results", 32'(nres), 32'd2);
    check("b2b_period",  32'(rise[1] - rise[0]), 32'd6);
    check("sb_drained",  32'(sb_q.size()), 32'd0);
    tick();

`ifdef PARITY_CHK_ERR_CNT_EN
    // Error counter: clear, three error frames and one clean frame
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("errcnt_clear", 32'(err_cnt), 32'd0);
    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0E, "ec1");
    take_result("ec1");
    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h00, "ec2");
    take_result("ec2");
    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, "ec_clean");
    take_result("ec_clean");
    send_frame(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, "ec3");
    take_result("ec3");
    check("errcnt_three", 32'(err_cnt), 32'd3);

    // Saturation near the top of the range
    force dut.r_err_cnt = 16'hFFFE;
    tick();
    release dut.r_err_cnt;
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, "sat1");
    take_result("sat1");
    check("errcnt_ffff", 32'(err_cnt), 32'hFFFF);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, "sat2");
    take_result("sat2");
    check("errcnt_sat", 32'(err_cnt), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_parity_frame_chk

`default_nettype wire

// File: doc/parity_frame_chk.md
# parity_frame_chk

Column-parity frame checker placed directly downstream of the team's XOR primitive cells. It accepts a stream of fixed-length frames of `DATA_W`-bit words over a valid/ready handshake. Each frame is `FRAME_LEN` data words followed by one parity word. The block XOR-accumulates the data words, compares the result against the parity word, and presents a syndrome and error flag through a result handshake.

## Interface
- `DATA_W`, default 8: word width in bits; must be at least 1.
- `FRAME_LEN`, default 4: data words per frame, excluding the parity word; must be at least 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_data`  in  DATA_W  input word (data or parity, by position in the frame).
- `in_ready`  out  1  block can accept a word.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_syndrome`  out  DATA_W  accumulated XOR of the data words XOR the parity word.
- `res_err`  out  1  OR-reduction of `res_syndrome`.
- `err_cnt`  out  16  error-frame count; present only with `PARITY_CHK_ERR_CNT_EN`.

## Operation
- A word is accepted on a cycle where `in_valid && in_ready`.
- Words offered while `in_ready` = 0 are ignored and not consumed.
- FSM states:
  - ACC: accepting data words; `in_ready` = 1.
  - CHK: accepting the parity word; `in_ready` = 1.
  - REPORT: result held; `in_ready` = 0, `res_valid` = 1.
- ACC behaviour:
  - Each accepted word updates `acc <= acc ^ in_data` and `cnt <= cnt + 1`.
  - On the accept that brings `cnt` to `FRAME_LEN`, go to CHK.
- CHK behaviour:
  - On accept, `syn <= acc ^ in_data` and go to REPORT.
- REPORT behaviour:
  - On `res_valid && res_ready`: `acc <= 0`, `cnt <= 0`, go to ACC.
- `res_err` = `|res_syndrome`, combinational from the registered syndrome.
- `res_syndrome` and `res_err` are stable for as long as `res_valid` is high.
- All XOR datapath bits are built from the `xor_word` sub-module (per-bit gate primitives); there are no behavioural XORs in the top level.
- Counter width is `$clog2(FRAME_LEN+1)`. `cnt` never exceeds `FRAME_LEN`; there is no wrap inside a frame.

## Timing
- Reset values:
  - FSM in ACC.
  - `acc`, `cnt`, `syn` = 0.
  - `in_ready` = 1, `res_valid` = 0, `res_syndrome` = 0, `res_err` = 0, `err_cnt` = 0.
- Latency: `res_valid` rises on the cycle after the parity word is accepted.
- Throughput:
  - One word per cycle while `in_ready` = 1.
  - Minimum frame period is `FRAME_LEN` + 2 cycles when `res_ready` is held high.
- Result handshake:
  - `res_valid` stays high until `res_ready` is sampled high.
  - `in_ready` rises on the cycle after the result handshake.
  - A simultaneous `in_valid` in the handshake cycle is not accepted.
- Reset mid-frame: immediate clear of all state. The partial frame is discarded and no result is issued.
- `res_ready` high while `res_valid` = 0 has no effect.

## Configuration
- `PARITY_CHK_ERR_CNT_EN` defined:
  - Adds the `err_cnt` port and register.
  - `err_cnt` increments by 1 on each result handshake with `res_err` = 1.
  - It saturates at 0xFFFF and is cleared only by `rst`.
- Not defined: no `err_cnt` port and no counter logic; all other behaviour is identical.

## Structure
- Shared package `parity_chk_pkg` holds:
  - FSM state enum (ACC, CHK, REPORT).
  - `ERR_CNT_W` = 16 constant.
  - Counter-width helper function.
- One sub-module, `xor_word`:
  - Parameter `DATA_W`; ports `a`, `b`, `y`.
  - A generate loop instantiates one gate-primitive `xor` per bit.
  - Used twice in the top level: the accumulator update and the syndrome computation.

## Test plan
All cases use `DATA_W` = 8 and `FRAME_LEN` = 4.
- Clean frame: data 0x01, 0x02, 0x04, 0x08, parity 0x0F -> one cycle later `res_valid` = 1, `res_syndrome` = 0x00, `res_err` = 0.
- Single-bit error: same data, parity 0x0E -> `res_syndrome` = 0x01, `res_err` = 1.
- Backpressure:
  - `res_ready` low for 3 cycles after `res_valid` rises -> `res_valid` and the syndrome are held, `in_ready` = 0, and offered words are not consumed.
  - Raising `res_ready` -> `in_ready` = 1 on the next cycle.
- Reset mid-frame:
  - Assert `rst` after 2 data words (0xAA, 0x55) -> all outputs at reset values, no result issued.
  - Next frame 0x10, 0x20, 0x40, 0x80, parity 0xF0 -> `res_err` = 0.
- Back-to-back frames: two frames with `res_ready` tied high and `in_valid` tied high -> results in the expected order, 6-cycle frame period, and the accumulator is cleared between frames.
- With `PARITY_CHK_ERR_CNT_EN`: three error frames and one clean frame -> `err_cnt` = 3. Preloading via forced state near 0xFFFF confirms saturation at 0xFFFF.
